// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Initiator side of the instruction-memory read port. Holds the fetch PC,
//   presents it as the byte address to a combinational instruction memory,
//   and captures the returned word into a small prefetch FIFO that feeds
//   decode through a valid/ready handshake. Redirects from execute flush the
//   FIFO and restart fetch at the new target.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   im_addr        byte address to instruction memory (the fetch PC register)
//   im_instr       word returned by memory for im_addr, same cycle
//   redirect_valid one-cycle pulse: restart fetch at redirect_pc
//   redirect_pc    redirect target byte address
//   out_valid      FIFO head holds a valid entry
//   out_ready      decode accepts the head this cycle
//   out_instr      instruction at the FIFO head (0 while empty)
//   out_pc         byte address of out_instr (0 while empty)
//   fetch_fault    sticky: fetch stopped (misaligned redirect or PC out of range)
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned IM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fetch_fault
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]   fpc;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          fault_q;
  logic [31:0]   buf_pc    [DEPTH];
  logic [31:0]   buf_instr [DEPTH];

  logic in_range;
  logic pop;
  logic push;

  always_comb begin
    in_range = (fpc >> 2) < 32'(IM_WORDS);
    pop      = out_valid & out_ready;
    // A full FIFO can still accept a word when the head leaves this cycle.
    push     = !redirect_valid & !fault_q & in_range &
               ((count < CW'(DEPTH)) | pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc     <= RESET_PC;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      fault_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        buf_pc[i]    <= '0;
        buf_instr[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Redirect wins over push and pop; any popped head is squashed.
      fpc     <= redirect_pc;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      fault_q <= |redirect_pc[1:0];
    end else begin
      if (push) begin
        buf_pc[wr_ptr]    <= fpc;
        buf_instr[wr_ptr] <= im_instr;
        wr_ptr            <= wr_ptr + PW'(1);
        fpc               <= fpc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Running off the end of the program stops fetch until a redirect.
      if (!in_range) begin
        fault_q <= 1'b1;
      end
    end
  end

  always_comb begin
    im_addr     = fpc;
    fetch_fault = fault_q;
    out_valid   = (count != '0);
    out_pc      = out_valid ? buf_pc[rd_ptr]    : '0;
    out_instr   = out_valid ? buf_instr[rd_ptr] : '0;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;
  localparam int unsigned IM_WORDS = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fetch_fault;

  instr_fetch_unit #(
    .RESET_PC(RESET_PC),
    .DEPTH(DEPTH),
    .IM_WORDS(IM_WORDS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .im_addr(im_addr),
    .im_instr(im_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  // Instruction memory: combinational read; out-of-range returns a marker.
  logic [31:0] mem [IM_WORDS];
  always_comb begin
    if ((im_addr >> 2) < 32'(IM_WORDS)) im_instr = mem[im_addr[6:2]];
    else                                 im_instr = 32'hBAD0_0000 ^ im_addr;
  end

  // Reference model: a queue of fetched {pc, instr} pairs plus the next
  // address to fetch and the stop flag.
  logic [63:0] q [$];
  logic [31:0] m_fpc;
  logic        m_fault;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_fpc   = RESET_PC;
    m_fault = 1'b0;
  endtask

  task automatic model_edge(input logic rdy, input logic rv, input logic [31:0] rpc);
    bit take;
    bit can_fetch;
    take = (q.size() != 0) && rdy;
    if (rv) begin
      q.delete();
      m_fpc   = rpc;
      m_fault = (rpc % 4) != 0;
    end else begin
      can_fetch = (m_fpc / 4) < IM_WORDS;
      if (take) void'(q.pop_front());
      if (!m_fault && can_fetch && q.size() < DEPTH) begin
        q.push_back({m_fpc, mem[m_fpc / 4]});
        m_fpc = m_fpc + 4;
      end
      if (!can_fetch) m_fault = 1'b1;
    end
  endtask

  task automatic check_all();
    logic [31:0] e_pc;
    logic [31:0] e_in;
    e_pc = (q.size() != 0) ? q[0][63:32] : 32'h0;
    e_in = (q.size() != 0) ? q[0][31:0]  : 32'h0;
    chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
    chk("out_pc", out_pc, e_pc);
    chk("out_instr", out_instr, e_in);
    chk("im_addr", im_addr, m_fpc);
    chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
  endtask

  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    model_edge(rdy, rv, rpc);
    @(posedge clk);
    #1;
    check_all();
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
  endtask

  // Reset asserted and released between clock edges.
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_im_addr", im_addr, RESET_PC);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'h0);
    #2 rst = 1'b1;
  endtask

  logic [31:0] last_pc;
  int unsigned r;

  initial begin
    rst            = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    for (int k = 0; k < int'(IM_WORDS); k++) mem[k] = 32'(k + 100);
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Streaming with out_ready held high.
    step(1'b1, 1'b0, 32'h0);
    chk("first_pc", out_pc, 32'h0);
    chk("first_instr", out_instr, 32'd100);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);
    chk("stream_pc", out_pc, 32'h10);

    // Stall: FIFO fills to two entries and the PC parks at 8.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0);
    chk("stall_im_addr", im_addr, 32'h8);
    chk("stall_head", out_pc, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("resume_pc4", out_pc, 32'h4);
    step(1'b1, 1'b0, 32'h0);
    chk("resume_pc8", out_pc, 32'h8);

    // Redirect while full.
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h40);
    chk("redir_flush", {31'b0, out_valid}, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("redir_pc", out_pc, 32'h40);
    chk("redir_instr", out_instr, 32'd116);

    // Misaligned redirect faults; an aligned one clears it.
    step(1'b1, 1'b1, 32'h42);
    chk("mis_fault", {31'b0, fetch_fault}, 32'h1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
    chk("mis_idle", {31'b0, out_valid}, 32'h0);
    step(1'b1, 1'b1, 32'h10);
    chk("mis_clear", {31'b0, fetch_fault}, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("mis_resume", out_pc, 32'h10);

    // Run off the end of the program.
    last_pc = 32'hFFFF_FFFF;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, 32'h0);
      if (out_valid) last_pc = out_pc;
    end
    chk("end_last_pc", last_pc, 32'h7C);
    chk("end_im_addr", im_addr, 32'h80);
    chk("end_fault", {31'b0, fetch_fault}, 32'h1);
    chk("end_drained", {31'b0, out_valid}, 32'h0);

    // Asynchronous reset with two entries buffered.
    step(1'b1, 1'b1, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("pre_rst_full", {31'b0, out_valid}, 32'h1);
    do_reset();
    step(1'b1, 1'b0, 32'h0);
    chk("post_rst_pc", out_pc, RESET_PC);

    // Randomized traffic against the model with fresh memory contents.
    for (int k = 0; k < int'(IM_WORDS); k++) mem[k] = $urandom;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 31);
      if (r == 0)      step(1'($urandom), 1'b1, {$urandom_range(0, IM_WORDS - 1), 2'b00});
      else if (r == 1) step(1'($urandom), 1'b1, 32'($urandom_range(0, IM_WORDS * 4 + 15)));
      else if (r == 2) step(1'($urandom), 1'b1, {$urandom_range(IM_WORDS - 3, IM_WORDS + 2), 2'b00});
      else             step(($urandom % 4) != 0, 1'b0, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface.
- Holds the fetch PC and drives the word-aligned byte address to the instruction memory. The memory returns the word combinationally, and this block captures it into a small prefetch FIFO.
- Presents {pc, instr} to decode with a valid/ready handshake.
- Accepts branch/jump redirects from execute, which flush the FIFO and restart fetch.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset (word aligned).
- DEPTH, 2, prefetch FIFO entries (power of 2, ≥2).
- IM_WORDS, 32, number of valid instruction words; byte addresses ≥ IM_WORDS*4 are out of range.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- im_addr  out  32  byte address to instruction memory; equals the fetch PC register
- im_instr  in  32  instruction word returned by memory for im_addr (valid in the same cycle)
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc
- redirect_pc  in  32  redirect target byte address
- out_valid  out  1  FIFO head holds a valid entry
- out_ready  in  1  decode accepts head this cycle
- out_instr  out  32  instruction at FIFO head
- out_pc  out  32  byte address of out_instr
- fetch_fault  out  1  sticky: fetching stopped (misaligned redirect or PC out of range)

Behaviour:
- Reset (rst=0, asynchronous):
  - fpc=RESET_PC; FIFO empty (count=0, rd/wr pointers 0); fetch_fault=0.
  - out_valid=0; out_instr=0 and out_pc=0 while empty.
  - im_addr=RESET_PC.
  - Reset asserted mid-operation discards all FIFO contents immediately.
- im_addr = fpc, driven directly from the register; no combinational path from any input.
- pop = out_valid & out_ready.
- push = !redirect_valid & !fetch_fault & in_range & (count<DEPTH | pop).
  - in_range = (fpc>>2) < IM_WORDS.
- On push: write {fpc, im_instr} at wr_ptr; fpc <= fpc+4 (32-bit wrap is irrelevant; the range check stops fetch first).
- count update per edge: +1 on push only, −1 on pop only, unchanged on push&pop.
  - Full with pop: push and pop occur in the same cycle.
  - Empty: out_valid=0 and pop cannot occur; no bypass, so a pushed word appears at the head one edge later.
- Latency:
  - The first instruction is visible on out_valid/out_pc/out_instr one edge after reset release.
  - Steady state delivers 1 instruction/cycle while out_ready=1.
- End of program: when fpc reaches IM_WORDS*4, set fetch_fault=1 and stop pushing.
  - Entries already buffered still drain normally.
- Redirect (redirect_valid=1) has priority over push and pop:
  - FIFO flushed (count=0, pointers 0), so out_valid=0 the next cycle.
  - No push in the redirect cycle.
  - A pop asserted in the same cycle is accepted by decode but the entry is discarded anyway; the consumer treats it as squashed.
  - If redirect_pc[1:0]==0: fpc<=redirect_pc and fetch_fault<=0; fetch resumes the following cycle.
  - If redirect_pc[1:0]!=0: fpc<=redirect_pc and fetch_fault<=1; no further pushes.
  - A redirect to an aligned but out-of-range address sets fetch_fault on the next cycle via the in_range check.
- Back-to-back redirects: each one flushes; only the last target takes effect.
- fetch_fault clears only on reset or on an aligned redirect.
- Outputs out_instr and out_pc are the FIFO head registers; they hold stable while out_valid=1 and out_ready=0.

Test Plan:
- Reset release, out_ready=1, im_instr model = memory of 32 words with word k = k+100:
  - out_valid=1 from edge 1.
  - out_pc sequence 0,4,8,…; out_instr 100,101,….
  - One instruction per cycle.
- out_ready=0 for 5 cycles after reset:
  - count saturates at 2; im_addr holds at 8.
  - out_pc=0 stays stable.
  - Raising out_ready delivers 0,4,8 with no gap or duplicate.
- redirect_valid pulse with redirect_pc=0x40 while FIFO full:
  - next cycle out_valid=0.
  - following cycle out_pc=0x40, out_instr=116; no stale entry appears.
- redirect_pc=0x42:
  - fetch_fault=1 next edge; no pushes; out_valid stays 0.
  - A later redirect to 0x10 clears the fault; out_pc=0x10 appears.
- Run to end, IM_WORDS=32:
  - last delivered out_pc=0x7C; fetch_fault=1.
  - im_addr stays 0x80; out_valid=0 after drain.
- Assert rst with FIFO holding 2 entries and out_ready=0:
  - out_valid=0 immediately (asynchronously).
  - im_addr=RESET_PC; after release, out_pc restarts at 0.
